// File: rtl/ddr_port1_reader.sv
// Purpose: streams the frame buffer out of MCB port 1 to the HDMI line buffer, one burst outstanding.
// Latency: FIFO pop -> pix_valid 1 cycle; last pop of a burst -> next command strobe 2 cycles.
// Backpressure: pix_ready low holds pix_data and stops pops; p1_cmd_full stalls command issue.
module ddr_port1_reader #(
    parameter int unsigned FRAME_WORDS = 307200,
    parameter int unsigned BURST_LEN   = 32,
    parameter logic [29:0] BASE_ADDR   = 30'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_calib_done,
    input  logic        frame_start,
    input  logic        p1_cmd_full,
    output logic        p1_cmd_en,
    output logic [2:0]  p1_cmd_instr,
    output logic [5:0]  p1_cmd_bl,
    output logic [29:0] p1_cmd_byte_addr,
    input  logic [31:0] p1_rd_data,
    input  logic        p1_rd_empty,
    output logic        p1_rd_en,
    output logic [31:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        frame_done,
    output logic        underrun
);
    localparam int IW = $clog2(FRAME_WORDS + 1);
    localparam logic [IW-1:0] FW_I      = IW'(FRAME_WORDS);
    localparam logic [IW-1:0] BL_I      = IW'(BURST_LEN);
    localparam logic [6:0]    LAST_BEAT = 7'(BURST_LEN - 1);

    localparam logic [2:0] WAIT_CALIB = 3'd0;
    localparam logic [2:0] IDLE       = 3'd1;
    localparam logic [2:0] ISSUE      = 3'd2;
    localparam logic [2:0] DRAIN      = 3'd3;
    localparam logic [2:0] FLUSH      = 3'd4;

    logic [2:0]    state;
    logic [IW-1:0] word_idx;
    logic [6:0]    beat_cnt;
    logic          pix_last;
    logic          burst_end;
    logic          frame_end;
    logic          pix_take;

    assign p1_cmd_instr = 3'b001;
    assign p1_cmd_bl    = 6'(BURST_LEN - 1);

    always_comb begin
        p1_rd_en = 1'b0;
        if (state == DRAIN)
            p1_rd_en = !p1_rd_empty && (!pix_valid || pix_ready);
        else if (state == FLUSH)
            p1_rd_en = !p1_rd_empty;
    end

    assign burst_end = p1_rd_en && (beat_cnt == LAST_BEAT);
    assign frame_end = (word_idx + BL_I) == FW_I;
    assign pix_take  = pix_valid && pix_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= WAIT_CALIB;
            word_idx         <= '0;
            beat_cnt         <= '0;
            p1_cmd_en        <= 1'b0;
            p1_cmd_byte_addr <= BASE_ADDR;
            pix_data         <= '0;
            pix_valid        <= 1'b0;
            pix_last         <= 1'b0;
            frame_done       <= 1'b0;
            underrun         <= 1'b0;
        end else begin
            p1_cmd_en  <= 1'b0;
            frame_done <= pix_take && pix_last;
            if (pix_take) begin
                pix_valid <= 1'b0;
                pix_last  <= 1'b0;
            end
            // Starving the consumer counts only once the frame has produced its first word.
            if ((state == ISSUE || state == DRAIN) && pix_ready && !pix_valid &&
                (word_idx != '0 || beat_cnt != '0))
                underrun <= 1'b1;

            case (state)
                WAIT_CALIB: begin
                    if (mem_calib_done)
                        state <= IDLE;
                end
                IDLE: begin
                    if (frame_start) begin
                        word_idx <= '0;
                        beat_cnt <= '0;
                        underrun <= 1'b0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (frame_start) begin
                        word_idx <= '0;
                        beat_cnt <= '0;
                        underrun <= 1'b0;
                    end else if (!p1_cmd_full) begin
                        p1_cmd_en        <= 1'b1;
                        p1_cmd_byte_addr <= BASE_ADDR + (30'(word_idx) << 2);
                        beat_cnt         <= '0;
                        state            <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (p1_rd_en)
                        beat_cnt <= beat_cnt + 7'd1;
                    if (frame_start) begin
                        // Drop the pending word; remaining beats are drained in FLUSH.
                        pix_valid <= 1'b0;
                        pix_last  <= 1'b0;
                        underrun  <= 1'b0;
                        if (burst_end) begin
                            beat_cnt <= '0;
                            word_idx <= '0;
                            state    <= ISSUE;
                        end else begin
                            state <= FLUSH;
                        end
                    end else if (p1_rd_en) begin
                        pix_data  <= p1_rd_data;
                        pix_valid <= 1'b1;
                        pix_last  <= burst_end && frame_end;
                        if (burst_end) begin
                            beat_cnt <= '0;
                            word_idx <= word_idx + BL_I;
                            state    <= frame_end ? IDLE : ISSUE;
                        end
                    end
                end
                FLUSH: begin
                    pix_valid <= 1'b0;
                    pix_last  <= 1'b0;
                    if (p1_rd_en)
                        beat_cnt <= beat_cnt + 7'd1;
                    if (burst_end) begin
                        beat_cnt <= '0;
                        word_idx <= '0;
                        underrun <= 1'b0;
                        state    <= ISSUE;
                    end
                end
                default: state <= WAIT_CALIB;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_port1_reader.sv
// Bench for ddr_port1_reader: an MCB port-1 model answers read commands with addr/4 data,
// and scoreboards hold the expected command addresses and pixel words of each frame.
module tb_ddr_port1_reader;
    localparam int unsigned FW   = 128;
    localparam int unsigned BL   = 32;
    localparam logic [29:0] BASE = 30'h1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_calib_done = 1'b0;
    logic        frame_start = 1'b0;
    logic        p1_cmd_full = 1'b0;
    logic        p1_cmd_en;
    logic [2:0]  p1_cmd_instr;
    logic [5:0]  p1_cmd_bl;
    logic [29:0] p1_cmd_byte_addr;
    logic [31:0] p1_rd_data = 32'h0;
    logic        p1_rd_empty = 1'b1;
    logic        p1_rd_en;
    logic [31:0] pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic        frame_done;
    logic        underrun;

    int total = 0;
    int bad = 0;
    int strobe_cnt = 0;
    int fd_cnt = 0;
    int ready_mode = 1;  // 0 never, 1 follows valid, 2 toggles, 3 always
    logic fifo_hold = 1'b0;

    logic [32:0] exp_pix[$];
    logic [29:0] exp_cmd[$];
    logic [31:0] rdq[$];

    always #5 clk = ~clk;

    ddr_port1_reader #(.FRAME_WORDS(FW), .BURST_LEN(BL), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .mem_calib_done(mem_calib_done), .frame_start(frame_start),
        .p1_cmd_full(p1_cmd_full), .p1_cmd_en(p1_cmd_en), .p1_cmd_instr(p1_cmd_instr),
        .p1_cmd_bl(p1_cmd_bl), .p1_cmd_byte_addr(p1_cmd_byte_addr), .p1_rd_data(p1_rd_data),
        .p1_rd_empty(p1_rd_empty), .p1_rd_en(p1_rd_en), .pix_data(pix_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .frame_done(frame_done),
        .underrun(underrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        cyc(1);
        frame_start = 1'b0;
    endtask

    task automatic push_frame();
        for (int w = 0; w < int'(FW); w++)
            exp_pix.push_back({(w == int'(FW) - 1), 32'h400 + 32'(w)});
        for (int b = 0; b < int'(FW / BL); b++)
            exp_cmd.push_back(BASE + 30'(b * int'(BL) * 4));
    endtask

    task automatic wait_accepted(input int n, input string tag);
        int i = 0;
        while (exp_pix.size() > int'(FW) - n && i < 5000) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(exp_pix.size() <= int'(FW) - n), 32'd1);
    endtask

    task automatic wait_frame(input int target, input string tag);
        int i = 0;
        while (fd_cnt < target && i < 5000) begin
            @(negedge clk);
            i++;
        end
        cyc(2);
        check(tag, fd_cnt, target);
        check({tag, "_pix_left"}, exp_pix.size(), 0);
        check({tag, "_cmd_left"}, exp_cmd.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_en"}, p1_cmd_en, 0);
        check({tag, "_instr"}, p1_cmd_instr, 3'b001);
        check({tag, "_bl"}, p1_cmd_bl, BL - 1);
        check({tag, "_addr"}, p1_cmd_byte_addr, BASE);
        check({tag, "_rd_en"}, p1_rd_en, 0);
        check({tag, "_pix_data"}, pix_data, 0);
        check({tag, "_pix_valid"}, pix_valid, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_underrun"}, underrun, 0);
    endtask

    // MCB port-1 model, consumer model and output monitors.
    initial begin : mcb_model
        logic        s_rd_en, s_cmd, p_stall, p_fs, fd_exp;
        logic [29:0] s_addr;
        logic [31:0] p_dat;
        logic [32:0] e;
        p_stall = 1'b0; p_fs = 1'b0; fd_exp = 1'b0; p_dat = '0;
        forever begin
            @(negedge clk);
            #1;
            case (ready_mode)
                0: pix_ready = 1'b0;
                1: pix_ready = pix_valid;
                2: pix_ready = !pix_ready;
                default: pix_ready = 1'b1;
            endcase
            #3;
            s_rd_en = p1_rd_en;
            s_cmd   = p1_cmd_en && !reset;
            s_addr  = p1_cmd_byte_addr;
            if (reset) begin
                fd_exp  = 1'b0;
                p_stall = 1'b0;
            end else begin
                check("frame_done", frame_done, fd_exp);
                fd_exp = 1'b0;
                if (frame_done) fd_cnt++;
                if (s_cmd) begin
                    strobe_cnt++;
                    check("cmd_instr", p1_cmd_instr, 3'b001);
                    check("cmd_bl", p1_cmd_bl, BL - 1);
                    check("cmd_one_outstanding", rdq.size(), 0);
                    if (exp_cmd.size() == 0) check("cmd_extra", exp_cmd.size(), 1);
                    else check("cmd_addr", s_addr, exp_cmd.pop_front());
                end
                if (p_stall && !p_fs) begin
                    check("stall_valid", pix_valid, 1);
                    check("stall_data", pix_data, p_dat);
                end
                if (pix_valid && pix_ready) begin
                    if (exp_pix.size() == 0) begin
                        check("pix_extra", exp_pix.size(), 1);
                    end else begin
                        e = exp_pix.pop_front();
                        check("pix_data", pix_data, e[31:0]);
                        fd_exp = e[32];
                    end
                end
                p_stall = pix_valid && !pix_ready;
                p_dat   = pix_data;
                p_fs    = frame_start;
            end
            @(posedge clk);
            #1;
            if (reset) begin
                rdq.delete();
            end else begin
                if (s_rd_en && rdq.size() != 0) void'(rdq.pop_front());
                if (s_cmd)
                    for (int i = 0; i < int'(BL); i++) rdq.push_back(32'(s_addr >> 2) + 32'(i));
            end
            p1_rd_empty = fifo_hold || (rdq.size() == 0);
            p1_rd_data  = (rdq.size() != 0) ? rdq[0] : 32'h0;
        end
    end

    initial begin : stimulus
        int s0;
        int i;
        cyc(3);
        check_reset_vals("reset");
        reset = 1'b0;

        // frame_start before calibration must not start a stream.
        pulse_fs();
        cyc(10);
        check("precalib_no_cmd", strobe_cnt, 0);
        mem_calib_done = 1'b1;
        cyc(5);
        check("calib_no_cmd", strobe_cnt, 0);
        check("calib_no_pix", pix_valid, 0);

        // Frame 1 with the command FIFO full at the second burst.
        push_frame();
        pulse_fs();
        wait_accepted(31, "wait_burst1");
        p1_cmd_full = 1'b1;
        s0 = strobe_cnt;
        check("strobes_before_hold", s0, 1);
        cyc(10);
        check("hold_no_strobe", strobe_cnt, s0);
        p1_cmd_full = 1'b0;
        cyc(2);
        check("strobe_first_free", strobe_cnt, s0 + 1);
        mem_calib_done = 1'b0;
        wait_frame(1, "frame1");
        check("frame1_underrun", underrun, 0);
        check("frame1_strobes", strobe_cnt, 4);

        // Frame 2 with a toggling consumer.
        ready_mode = 2;
        push_frame();
        pulse_fs();
        wait_frame(2, "frame2");

        // Frame 3 restarted after 10 beats of burst 3.
        ready_mode = 1;
        push_frame();
        pulse_fs();
        wait_accepted(74, "wait_burst3");
        ready_mode = 0;
        cyc(1);
        frame_start = 1'b1;
        exp_pix.delete();
        exp_cmd.delete();
        push_frame();
        s0 = strobe_cnt;
        cyc(1);
        frame_start = 1'b0;
        ready_mode = 1;
        i = 0;
        while (strobe_cnt == s0 && i < 200) begin
            check("flush_valid", pix_valid, 0);
            cyc(1);
            i++;
        end
        check("restart_strobe", strobe_cnt, s0 + 1);
        wait_frame(3, "frame3");
        check("frame3_underrun", underrun, 0);

        // Frame 4 with the read FIFO starved while the consumer is ready.
        push_frame();
        pulse_fs();
        wait_accepted(40, "wait_burst2");
        check("underrun_pre", underrun, 0);
        fifo_hold = 1'b1;
        ready_mode = 3;
        cyc(5);
        check("underrun_set", underrun, 1);
        fifo_hold = 1'b0;
        ready_mode = 1;
        wait_frame(4, "frame4");
        check("underrun_sticky", underrun, 1);

        // Frame 5 clears underrun, then reset lands mid-burst.
        push_frame();
        pulse_fs();
        cyc(1);
        check("underrun_cleared", underrun, 0);
        wait_accepted(50, "wait_mid");
        reset = 1'b1;
        exp_pix.delete();
        exp_cmd.delete();
        cyc(2);
        check_reset_vals("midreset");
        reset = 1'b0;
        s0 = strobe_cnt;
        cyc(8);
        check("post_reset_no_cmd", strobe_cnt, s0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
